// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory-stage access unit: FSM states, rv32i load/store
// width encodings and the latched data-cache request payload.
package mem_access_unit_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned MASK_W = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mau_state_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [MASK_W-1:0] wmask;
        logic [XLEN-1:0]   wdata;
    } dmem_req_t;

    // funct3[1:0] carries the access size for both loads and stores
    function automatic logic is_misaligned(logic [2:0] funct3, logic [1:0] off);
        case (funct3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-cache request/response bus between the access unit (master) and the cache (slave).
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    logic [XLEN-1:0]   dmem_address;
    logic              dmem_read;
    logic              dmem_write;
    logic [MASK_W-1:0] dmem_wmask;
    logic [XLEN-1:0]   dmem_wdata;
    logic [XLEN-1:0]   dmem_rdata;
    logic              dmem_resp;

    modport master (
        output dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp
    );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Lane-selects the addressed byte/halfword/word from a read word and
// sign- or zero-extends it according to the load width code.
module mem_access_unit_load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data_c
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        data_c  = shifted;
        case (load_funct3_t'(funct3))
            LB:      data_c = {{24{shifted[7]}}, shifted[7:0]};
            LH:      data_c = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     data_c = {24'h0, shifted[7:0]};
            LHU:     data_c = {16'h0, shifted[15:0]};
            default: data_c = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access engine: issues one cache read/write per load/store,
// stalls the pipeline until the response, and returns the extended load data.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic                     is_load,
    input  logic                     is_store,
    input  logic [2:0]               funct3,
    input  logic [XLEN-1:0]          addr_in,
    input  logic [XLEN-1:0]          wdata_in,
    mem_access_unit_if.master        dmem,
    output logic                     stall,
    output logic                     done,
    output logic [XLEN-1:0]          load_data,
    output logic                     misaligned,
    output logic                     timeout
);

    localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    mau_state_t        state_q, state_d;
    dmem_req_t         req_q, req_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic              misaligned_q, misaligned_d;
    logic              timeout_q, timeout_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_op;
    logic [1:0]        off;
    logic [XLEN-1:0]   ext_c;

    mem_access_unit_load_extend u_load_extend (
        .funct3 (funct3_q),
        .off    (off_q),
        .rdata  (dmem.dmem_rdata),
        .data_c (ext_c)
    );

    // Next-state, request latching, watchdog and combinational stall
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        read_d       = 1'b0;
        write_d      = 1'b0;
        done_d       = 1'b0;
        load_data_d  = '0;
        misaligned_d = 1'b0;
        timeout_d    = timeout_q;
        wait_cnt_d   = wait_cnt_q;
        stall        = 1'b0;
        mem_op       = valid_in & (is_load | is_store);
        off          = addr_in[1:0];

        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (is_misaligned(funct3, off)) begin
                        misaligned_d = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        state_d     = BUSY;
                        funct3_d    = funct3;
                        off_d       = off;
                        read_d      = is_load;
                        write_d     = ~is_load;
                        wait_cnt_d  = '0;
                        req_d.addr  = {addr_in[XLEN-1:2], 2'b00};
                        req_d.wdata = is_load ? '0 : (wdata_in << {off, 3'b000});
                        if (is_load) begin
                            req_d.wmask = '0;
                        end else begin
                            case (store_funct3_t'(funct3))
                                SB:      req_d.wmask = 4'b0001 << off;
                                SH:      req_d.wmask = 4'b0011 << off;
                                default: req_d.wmask = 4'b1111;
                            endcase
                        end
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (dmem.dmem_resp) begin
                    state_d     = RESP;
                    done_d      = 1'b1;
                    load_data_d = read_q ? ext_c : '0;
                end else begin
                    read_d  = read_q;
                    write_d = write_q;
                    // Saturating watchdog; timeout stays set until reset
                    if (MAX_WAIT != 0 && wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        if (wait_cnt_d == WAIT_W'(MAX_WAIT)) begin
                            timeout_d = 1'b1;
                        end
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            funct3_q     <= '0;
            off_q        <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            done_q       <= 1'b0;
            load_data_q  <= '0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            read_q       <= read_d;
            write_q      <= write_d;
            done_q       <= done_d;
            load_data_q  <= load_data_d;
            misaligned_q <= misaligned_d;
            timeout_q    <= timeout_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign dmem.dmem_address = req_q.addr;
    assign dmem.dmem_read    = read_q;
    assign dmem.dmem_write   = write_q;
    assign dmem.dmem_wmask   = req_q.wmask;
    assign dmem.dmem_wdata   = req_q.wdata;
    assign done              = done_q;
    assign load_data         = load_data_q;
    assign misaligned        = misaligned_q;
    assign timeout           = timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// loads/stores checked against an arithmetic reference model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    mem_access_unit_if bus ();

    mem_access_unit #(.MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr_in    (addr_in),
        .wdata_in   (wdata_in),
        .dmem       (bus),
        .stall      (stall),
        .done       (done),
        .load_data  (load_data),
        .misaligned (misaligned),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && valid_in) begin
            assert (!(is_load && is_store)) else $error("illegal: is_load and is_store both high");
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Access size in bytes from the width code
    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Reference load result: pick the addressed bytes, then extend
    function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
        longint v;
        v = longint'(rd) / (longint'(1) << (8 * off));
        case (f3)
            3'b000: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'b001: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'b100: v = v % 256;
            3'b101: v = v % 65536;
            default: v = longint'(rd);
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_mask(input logic [2:0] f3, input int off);
        int bytes;
        bytes = size_of(f3);
        return 32'(((1 << bytes) - 1) << off);
    endfunction

    // One load/store: request cycle, `delay` BUSY cycles, RESP cycle, one idle cycle
    task automatic do_access(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd, input int delay,
                             input bit use_exp, input logic [31:0] exp_ld);
        int          off;
        bit          bad;
        logic [31:0] exp_wd;
        logic [31:0] exp_data;
        off      = int'(addr % 4);
        bad      = (addr % size_of(f3)) != 0;
        exp_wd   = wd << (8 * off);
        exp_data = ld ? (use_exp ? exp_ld : model_load(f3, off, rd)) : 32'h0;

        @(negedge clk);
        valid_in = 1'b1; is_load = ld; is_store = !ld; funct3 = f3;
        addr_in = addr; wdata_in = wd; bus.dmem_resp = 1'b0;
        #1;
        check("stall_request", 32'(stall), 32'(!bad));

        if (bad) begin
            @(negedge clk);
            valid_in = 1'b0;
            #1;
            check("misaligned_pulse", 32'(misaligned), 32'h1);
            check("misaligned_no_read", 32'(bus.dmem_read), 32'h0);
            check("misaligned_no_write", 32'(bus.dmem_write), 32'h0);
            check("misaligned_no_stall", 32'(stall), 32'h0);
            @(negedge clk);
            #1;
            check("misaligned_clear", 32'(misaligned), 32'h0);
            check("misaligned_idle_read", 32'(bus.dmem_read), 32'h0);
            return;
        end

        for (int i = 1; i <= delay; i++) begin
            @(negedge clk);
            valid_in = 1'($urandom_range(0, 1));
            addr_in = $urandom; wdata_in = $urandom;
            bus.dmem_resp  = (i == delay);
            bus.dmem_rdata = (i == delay) ? rd : $urandom;
            #1;
            check("busy_read", 32'(bus.dmem_read), 32'(ld));
            check("busy_write", 32'(bus.dmem_write), 32'(!ld));
            check("busy_address", bus.dmem_address, addr & 32'hFFFF_FFFC);
            check("busy_wmask", 32'(bus.dmem_wmask), ld ? 32'h0 : model_mask(f3, off));
            if (!ld) check("busy_wdata", bus.dmem_wdata, exp_wd);
            check("busy_stall", 32'(stall), 32'h1);
            check("busy_done", 32'(done), 32'h0);
            check("busy_timeout", 32'(timeout), 32'h0);
        end

        @(negedge clk);
        bus.dmem_resp = 1'b0; bus.dmem_rdata = $urandom;
        valid_in = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
        addr_in = $urandom & 32'hFFFF_FFFC;
        #1;
        check("resp_done", 32'(done), 32'h1);
        check("resp_load_data", load_data, exp_data);
        check("resp_stall", 32'(stall), 32'h0);
        check("resp_read_dropped", 32'(bus.dmem_read), 32'h0);
        check("resp_write_dropped", 32'(bus.dmem_write), 32'h0);

        @(negedge clk);
        valid_in = 1'b0;
        bus.dmem_resp = 1'($urandom_range(0, 1));
        #1;
        check("after_done_clear", 32'(done), 32'h0);
        check("after_no_reissue", 32'(bus.dmem_read), 32'h0);
        check("after_stall", 32'(stall), 32'h0);
    endtask

    initial begin
        logic [2:0]  f3s [8];
        logic        lds [8];
        int          pick;
        logic [31:0] a;

        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010};
        lds = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b0; valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = 3'b0; addr_in = '0; wdata_in = '0;
        bus.dmem_rdata = '0; bus.dmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_read", 32'(bus.dmem_read), 32'h0);
        check("reset_write", 32'(bus.dmem_write), 32'h0);
        check("reset_wmask", 32'(bus.dmem_wmask), 32'h0);
        check("reset_address", bus.dmem_address, 32'h0);
        check("reset_load_data", load_data, 32'h0);
        check("reset_flags", {28'h0, stall, done, misaligned, timeout}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        do_access(1'b1, 3'b010, 32'h1000_0008, 32'h0, 32'hDEAD_BEEF, 3, 1'b1, 32'hDEAD_BEEF);
        do_access(1'b1, 3'b000, 32'h1000_0003, 32'h0, 32'h80FF_0000, 1, 1'b1, 32'hFFFF_FF80);
        do_access(1'b1, 3'b100, 32'h1000_0003, 32'h0, 32'h80FF_0000, 2, 1'b1, 32'h0000_0080);
        do_access(1'b1, 3'b001, 32'h1000_0002, 32'h0, 32'h8001_1234, 1, 1'b1, 32'hFFFF_8001);
        do_access(1'b0, 3'b000, 32'h1000_0001, 32'h0000_00AB, 32'h0, 3, 1'b0, 32'h0);
        do_access(1'b0, 3'b001, 32'h1000_0003, 32'h0000_1234, 32'h0, 2, 1'b0, 32'h0);
        do_access(1'b0, 3'b010, 32'h2000_0004, 32'hCAFE_F00D, 32'h0, 4, 1'b0, 32'h0);

        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 7);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(f3s[pick]) - 1);
            do_access(lds[pick], f3s[pick], a, $urandom, $urandom, $urandom_range(1, 4), 1'b0, 32'h0);
        end

        // Watchdog: never respond, then reset mid-BUSY
        @(negedge clk);
        valid_in = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
        addr_in = 32'h3000_0010; bus.dmem_resp = 1'b0;
        #1;
        check("wd_stall_request", 32'(stall), 32'h1);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            valid_in = 1'b0;
            #1;
            check("wd_read_held", 32'(bus.dmem_read), 32'h1);
            check("wd_timeout", 32'(timeout), 32'(i >= 5));
        end
        #2;
        rst = 1'b0;
        #1;
        check("rst_read", 32'(bus.dmem_read), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_address", bus.dmem_address, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h1234_5678;
        #1;
        check("late_resp_done0", 32'(done), 32'h0);
        @(negedge clk);
        bus.dmem_resp = 1'b0;
        #1;
        check("late_resp_done1", 32'(done), 32'h0);
        check("late_resp_load_data", load_data, 32'h0);
        check("late_resp_read", 32'(bus.dmem_read), 32'h0);
        check("late_resp_timeout", 32'(timeout), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage data-access engine. Consumes the execute-stage results: the ALU result is the effective address and rs2 is the store data.
- Issues one read or write per load/store to the data cache over a request/response handshake.
- Stalls the pipeline until the cache responds.
- Produces the aligned, sign- or zero-extended load result for writeback.

Parameters:
- MAX_WAIT, 0, maximum BUSY cycles before timeout error; 0 disables the watchdog.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- valid_in  in  1  memory-stage instruction valid
- is_load  in  1  instruction is a load
- is_store  in  1  instruction is a store
- funct3  in  3  load/store width code (rv32i load_funct3/store_funct3 encodings)
- addr_in  in  32  effective address (execute-stage ALU result)
- wdata_in  in  32  store data (execute-stage rs2)
- dmem_address  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_wmask  out  4  byte enables
- dmem_wdata  out  32  lane-shifted store data
- dmem_rdata  in  32  read data
- dmem_resp  in  1  cache response
- stall  out  1  hold upstream stages
- done  out  1  one-cycle pulse: access complete
- load_data  out  32  extended load result, valid while done=1
- misaligned  out  1  one-cycle pulse: misaligned access rejected
- timeout  out  1  sticky watchdog error, cleared only by reset

Behaviour:
- Reset (asynchronous, rst=0):
  - state=IDLE.
  - All outputs 0, including dmem_read/dmem_write/dmem_wmask/dmem_address/load_data/timeout.
  - Any in-flight access is abandoned.
- States: IDLE, BUSY, RESP.
- IDLE:
  - mem_op = valid_in & (is_load | is_store).
  - is_load & is_store both high is illegal; the bench asserts on it.
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
  - mem_op & aligned: stall=1 combinationally. Latch addr, funct3, load/store, wmask and shifted wdata. Next state BUSY.
  - mem_op & misaligned: no cache request; misaligned=1 for one cycle (registered); stall=0; stay IDLE.
  - No mem_op: stall=0; pass through.
- BUSY:
  - dmem_read or dmem_write held high, with address, mask and data stable from registers, up to and including the cycle dmem_resp is sampled high.
  - stall=1.
  - dmem_resp=1: capture the extended rdata; next state RESP. Request strobes drop in that next cycle.
  - Watchdog (MAX_WAIT>0): counter counts BUSY cycles. When it reaches MAX_WAIT with no resp, set timeout=1 and keep waiting; the counter saturates.
- RESP:
  - done=1; load_data valid (0 for stores); stall=0 so the pipeline advances on this edge.
  - Next state is always IDLE. valid_in is ignored this cycle, so the same instruction is never re-issued.
- Minimum latency: request accepted in cycle 0; strobes high cycles 1..k; done in cycle k+1.
- Store mask and data, with off=addr[1:0]:
  - SB: wmask=4'b0001<<off, wdata=wdata_in<<(8*off).
  - SH: wmask=4'b0011<<off, wdata=wdata_in<<(8*off).
  - SW: wmask=4'b1111.
  - Loads drive wmask=0.
- Load extraction: shift dmem_rdata right by 8*off.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- dmem_resp seen in IDLE or RESP (spurious, or arriving after reset) is ignored.
- Reset mid-BUSY: strobes drop immediately (async); no done pulse.

Decomposition:
- Shared package: state enum (mau_state_t {IDLE,BUSY,RESP}); reuse the existing load_funct3_t/store_funct3_t encodings.
- Sub-module load_extend: pure combinational, taking funct3, off and rdata and producing the extended word. It is unit-testable on its own.
- Mask/shift generation stays inline.

Test Plan:
- LW, addr=0x1000_0008, resp after 3 BUSY cycles, rdata=0xDEADBEEF:
  - dmem_address=0x1000_0008; dmem_read high exactly 3 cycles; stall high 4 cycles.
  - done in cycle 4, load_data=0xDEADBEEF.
- LB/LBU, addr=0x…03, rdata=0x80FF_0000 -> load_data=0xFFFFFF80 / 0x00000080.
- LH, addr=0x…02, rdata=0x8001_1234 -> 0xFFFF8001.
- SB, addr=0x…01, wdata=0x0000_00AB -> dmem_wmask=4'b0010, dmem_wdata=0x0000_AB00, dmem_write held until resp.
- SH, addr=0x…03 -> misaligned pulse one cycle; no dmem_read/dmem_write; stall never asserted.
- MAX_WAIT=4, never respond -> timeout rises after 4 BUSY cycles and stays high.
- Then rst low mid-BUSY: all strobes and timeout go 0 immediately.
- A later dmem_resp in IDLE produces no done pulse.
